// File: rtl/boot_manager.sv
// Power-up and boot sequencer: filters power_good, latches the DIP selections,
// drives the SPI image loader, then warms up before releasing the bubble interface.
module boot_manager #(
  parameter int IMG_W        = 3,
  parameter int FUNC_W       = 4,
  parameter int PG_FILTER    = 16,
  parameter int LOAD_TIMEOUT = 4800000,
  parameter int WARMUP       = 48000
) (
  input  logic              master_clock,
  input  logic              reset,
  input  logic              power_good,
  input  logic [IMG_W-1:0]  image_dip_switch,
  input  logic [FUNC_W-1:0] function_dip_switch,
  input  logic              loader_done,
  input  logic              flash_error,
  output logic              loader_start,
  output logic [IMG_W-1:0]  image_number,
  output logic [FUNC_W-1:0] function_mode,
  output logic              bubble_interface_enable,
  output logic              temperature_low,
  output logic              boot_error,
  output logic [2:0]        state_code
);

  localparam int PG_CW   = (PG_FILTER > 1) ? $clog2(PG_FILTER) : 1;
  localparam int LOAD_CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam int WARM_CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [PG_CW-1:0]   PG_LAST   = PG_CW'(PG_FILTER - 1);
  localparam logic [LOAD_CW-1:0] LOAD_LAST = LOAD_CW'(LOAD_TIMEOUT - 1);
  localparam logic [WARM_CW-1:0] WARM_LAST = WARM_CW'(WARMUP - 1);

  typedef enum logic [2:0] {
    S_WAIT_PG = 3'd0,
    S_LATCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_WARMUP  = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic              pg_meta_q, pg_s_q;
  logic [IMG_W-1:0]  img_meta_q, img_s_q;
  logic [FUNC_W-1:0] func_meta_q, func_s_q;

  logic [PG_CW-1:0]   pg_cnt_q, pg_cnt_d;
  logic [LOAD_CW-1:0] load_cnt_q, load_cnt_d;
  logic [WARM_CW-1:0] warm_cnt_q, warm_cnt_d;

  logic              loader_start_q;
  logic [IMG_W-1:0]  image_number_q;
  logic [FUNC_W-1:0] function_mode_q;
  logic              enable_q, temp_low_q, boot_error_q;

  // Counters default to zero so that leaving a state always clears them.
  always_comb begin
    state_d    = state_q;
    pg_cnt_d   = '0;
    load_cnt_d = '0;
    warm_cnt_d = '0;
    case (state_q)
      S_WAIT_PG: begin
        if (pg_s_q) begin
          if (pg_cnt_q == PG_LAST) state_d = S_LATCH;
          else                     pg_cnt_d = pg_cnt_q + 1'b1;
        end
      end
      S_LATCH: state_d = S_LOAD;
      S_LOAD: begin
        if (flash_error)                  state_d = S_FAULT;
        else if (loader_done)             state_d = S_WARMUP;
        else if (load_cnt_q == LOAD_LAST) state_d = S_FAULT;
        else                              load_cnt_d = load_cnt_q + 1'b1;
      end
      S_WARMUP: begin
        if (warm_cnt_q == WARM_LAST) state_d = S_RUN;
        else                         warm_cnt_d = warm_cnt_q + 1'b1;
      end
      S_RUN:   state_d = S_RUN;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_WAIT_PG;
    endcase
    // Power loss wins over every other transition outside WAIT_PG.
    if (state_q != S_WAIT_PG && !pg_s_q) begin
      state_d    = S_WAIT_PG;
      load_cnt_d = '0;
      warm_cnt_d = '0;
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      pg_meta_q       <= 1'b0;
      pg_s_q          <= 1'b0;
      img_meta_q      <= '0;
      img_s_q         <= '0;
      func_meta_q     <= '0;
      func_s_q        <= '0;
      state_q         <= S_WAIT_PG;
      pg_cnt_q        <= '0;
      load_cnt_q      <= '0;
      warm_cnt_q      <= '0;
      loader_start_q  <= 1'b0;
      image_number_q  <= '0;
      function_mode_q <= '0;
      enable_q        <= 1'b0;
      temp_low_q      <= 1'b1;
      boot_error_q    <= 1'b0;
    end else begin
      pg_meta_q   <= power_good;
      pg_s_q      <= pg_meta_q;
      img_meta_q  <= image_dip_switch;
      img_s_q     <= img_meta_q;
      func_meta_q <= function_dip_switch;
      func_s_q    <= func_meta_q;
      state_q     <= state_d;
      pg_cnt_q    <= pg_cnt_d;
      load_cnt_q  <= load_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      // Outputs track the next state so they change on the same edge as the state.
      loader_start_q <= (state_q == S_LATCH) && (state_d == S_LOAD);
      if (state_d == S_LATCH) begin
        image_number_q  <= ~img_s_q;
        function_mode_q <= ~func_s_q;
      end
      enable_q     <= (state_d == S_RUN);
      temp_low_q   <= (state_d != S_RUN);
      boot_error_q <= (state_d == S_FAULT);
    end
  end

  assign loader_start            = loader_start_q;
  assign image_number            = image_number_q;
  assign function_mode           = function_mode_q;
  assign bubble_interface_enable = enable_q;
  assign temperature_low         = temp_low_q;
  assign boot_error              = boot_error_q;
  assign state_code              = state_q;

endmodule

// File: tb/tb_boot_manager.sv
// Directed bench for boot_manager: a vector table walks boot, timeout, fault and
// reset scenarios; a hand loop covers short power_good glitches.
module tb_boot_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       pg;
  logic [2:0] img;
  logic [3:0] fn;
  logic       done, err;
  logic       start, en, tl, berr;
  logic [2:0] img_o, st;
  logic [3:0] fn_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_manager #(
    .IMG_W(3), .FUNC_W(4), .PG_FILTER(4), .LOAD_TIMEOUT(10), .WARMUP(8)
  ) dut (
    .master_clock(clk),
    .reset(rst),
    .power_good(pg),
    .image_dip_switch(img),
    .function_dip_switch(fn),
    .loader_done(done),
    .flash_error(err),
    .loader_start(start),
    .image_number(img_o),
    .function_mode(fn_o),
    .bubble_interface_enable(en),
    .temperature_low(tl),
    .boot_error(berr),
    .state_code(st)
  );

  typedef struct {
    logic       rst, pg;
    logic [2:0] img;
    logic [3:0] fn;
    logic       done, err;
    int         n;
    logic [2:0] st;
    logic       start;
    logic [2:0] eimg;
    logic [3:0] efn;
    logic       en, tl, berr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic p, logic [2:0] i, logic [3:0] f, logic d, logic e,
                              int n, logic [2:0] s, logic ls, logic [2:0] ei, logic [3:0] ef,
                              logic een, logic etl, logic eb);
    vec_t v;
    v.rst = r; v.pg = p; v.img = i; v.fn = f; v.done = d; v.err = e; v.n = n;
    v.st = s; v.start = ls; v.eimg = ei; v.efn = ef; v.en = een; v.tl = etl; v.berr = eb;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pg = 1'b0; img = 3'b010; fn = 4'b1110; done = 1'b0; err = 1'b0;

    //                rst pg  img     fn       dn er  n   st  ls eimg  efn  en tl be
    vecs.push_back(mk(1, 0, 3'b010, 4'b1110, 0, 0, 2, 3'd0, 0, 3'd0, 4'd0, 0, 1, 0));
    // normal boot
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 5, 3'd0, 0, 3'd0, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd1, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd2, 1, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd2, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd2, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 1, 0, 1, 3'd3, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 7, 3'd3, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd4, 0, 3'd5, 4'd1, 1, 0, 0));
    // DIP change in RUN is ignored; power loss after 3 edges keeps selections
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 0, 5, 3'd4, 0, 3'd5, 4'd1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 4'b0000, 0, 0, 2, 3'd4, 0, 3'd5, 4'd1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 4'b0000, 0, 0, 1, 3'd0, 0, 3'd5, 4'd1, 0, 1, 0));
    // power back: new selections, then load timeout
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 0, 6, 3'd1, 0, 3'd0, 4'd15, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 0, 1, 3'd2, 1, 3'd0, 4'd15, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 0, 9, 3'd2, 0, 3'd0, 4'd15, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 0, 1, 3'd5, 0, 3'd0, 4'd15, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'b111, 4'b0000, 0, 0, 2, 3'd5, 0, 3'd0, 4'd15, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'b111, 4'b0000, 0, 0, 1, 3'd0, 0, 3'd0, 4'd15, 0, 1, 0));
    // flash_error and loader_done together
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 7, 3'd2, 1, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 1, 1, 1, 3'd5, 0, 3'd5, 4'd1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'b010, 4'b1110, 0, 0, 2, 3'd5, 0, 3'd5, 4'd1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'b010, 4'b1110, 0, 0, 1, 3'd0, 0, 3'd5, 4'd1, 0, 1, 0));
    // reset in WARMUP, reboot, reset in RUN, reset during loader_start
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 7, 3'd2, 1, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 1, 0, 1, 3'd3, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 2, 3'd3, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd0, 0, 3'd0, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 6, 3'd1, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd2, 1, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 1, 0, 1, 3'd3, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 8, 3'd4, 0, 3'd5, 4'd1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd0, 0, 3'd0, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 6, 3'd1, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd0, 0, 3'd0, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 6, 3'd1, 0, 3'd5, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b1110, 0, 0, 1, 3'd2, 1, 3'd5, 4'd1, 0, 1, 0));

    step(1);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; pg = vecs[i].pg; img = vecs[i].img; fn = vecs[i].fn;
      done = vecs[i].done; err = vecs[i].err;
      step(vecs[i].n);
      checks++;
      if ({st, start, img_o, fn_o, en, tl, berr} !==
          {vecs[i].st, vecs[i].start, vecs[i].eimg, vecs[i].efn, vecs[i].en, vecs[i].tl, vecs[i].berr}) begin
        errors++;
        $display("FAIL vec%0d: got st=%0d start=%b img=%0d fn=%0d en=%b tl=%b berr=%b, want st=%0d start=%b img=%0d fn=%0d en=%b tl=%b berr=%b",
                 i, st, start, img_o, fn_o, en, tl, berr, vecs[i].st, vecs[i].start,
                 vecs[i].eimg, vecs[i].efn, vecs[i].en, vecs[i].tl, vecs[i].berr);
      end else begin
        $display("vec%0d ok: st=%0d start=%b img=%0d fn=%0d en=%b tl=%b berr=%b",
                 i, st, start, img_o, fn_o, en, tl, berr);
      end
    end

    // Drop power, then short glitches of 3 high samples must never leave WAIT_PG.
    pg = 1'b0;
    step(3);
    checks++;
    if (st !== 3'd0) begin
      errors++;
      $display("FAIL glitch_entry: st=%0d want 0", st);
    end
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 6; c++) begin
        pg = (c < 3);
        step(1);
        checks++;
        if (st !== 3'd0 || start !== 1'b0) begin
          errors++;
          $display("FAIL glitch%0d_%0d: st=%0d start=%b want st=0 start=0", g, c, st, start);
        end
      end
      $display("glitch burst %0d: st=%0d start=%b", g, st, start);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_manager.md
# boot_manager

Parametrised power-up and boot sequencer for the BubbleDrive8 FPGA. It filters the BUBBLE SYSTEM `power_good` line and synchronises the on-board DIP switches. It latches the image and function selection once per power-up, starts the SPI image loader and waits for it to finish. It then runs a warm-up delay before enabling the bubble interface and clearing the TEMPERATURE LOW (READY) line; load failures are held as a fault until power cycles.

## Interface
- `IMG_W`, 3: image-select DIP width
- `FUNC_W`, 4: function DIP width
- `PG_FILTER`, 16: consecutive high samples of synced power_good required before boot (≥1)
- `LOAD_TIMEOUT`, 4800000: max cycles in LOAD before fault (≥2)
- `WARMUP`, 48000: cycles in WARMUP before RUN (≥1)
- `master_clock` in 1: 48 MHz master clock; the only clock
- `reset` in 1: synchronous, active-high
- `power_good` in 1: asynchronous, from BUBBLE SYSTEM board
- `image_dip_switch` in IMG_W: asynchronous, switch-on = 0
- `function_dip_switch` in FUNC_W: asynchronous, switch-on = 0
- `loader_done` in 1: SPI loader completion, level or pulse
- `flash_error` in 1: SPI loader failure, level or pulse
- `loader_start` out 1: one-cycle start pulse to the SPI loader
- `image_number` out IMG_W: latched `~image_dip_switch`
- `function_mode` out FUNC_W: latched `~function_dip_switch`
- `bubble_interface_enable` out 1: 1 = BubbleInterface running
- `temperature_low` out 1: 1 = not ready (READY line to host)
- `boot_error` out 1: 1 = load failed or timed out
- `state_code` out 3: current state, for debug

## Operation
- Inputs `power_good` and both DIP buses each pass through a 2-flop synchroniser. The synchronised signals are `pg_s`, `img_s` and `func_s`. All decisions use the synchronised values.
- States and encodings:
  - WAIT_PG = 0
  - LATCH = 1
  - LOAD = 2
  - WARMUP = 3
  - RUN = 4
  - FAULT = 5
- WAIT_PG:
  - Filter counter increments on each edge with `pg_s=1` and clears when `pg_s=0`.
  - When `pg_s` has been 1 at PG_FILTER consecutive edges, go to LATCH.
- LATCH, one cycle:
  - `image_number <= ~img_s`, `function_mode <= ~func_s`.
  - Go to LOAD.
  - These are the only edges on which the two outputs change, except reset.
- LOAD:
  - `loader_start` is high for the first LOAD cycle only.
  - The timeout counter starts at 0 on entry.
  - `flash_error=1` → FAULT.
  - Else `loader_done=1` → WARMUP.
  - Else, when the counter reaches LOAD_TIMEOUT-1 → FAULT.
  - `flash_error` has priority over `loader_done` in the same cycle.
- WARMUP: count WARMUP cycles, then go to RUN.
- RUN: `bubble_interface_enable=1`, `temperature_low=0`.
- FAULT:
  - `boot_error=1`, enable 0, `temperature_low=1`.
  - Stays in FAULT while `pg_s=1`.
- Power loss: `pg_s=0` in any state other than WAIT_PG → WAIT_PG on the next edge.
  - Counters clear and `boot_error` clears.
  - Image and function selections keep their last latched values.
- Outputs are registered and decoded from the next state. An output change therefore appears on the same edge as the state change.
- Counter widths are $clog2 of the respective parameter (min 1). No wrap: counters saturate or clear on state exit.

## Timing
- Reset values:
  - state WAIT_PG
  - `loader_start` 0
  - `image_number` 0, `function_mode` 0
  - `bubble_interface_enable` 0
  - `temperature_low` 1
  - `boot_error` 0
  - `state_code` 0
  - synchronisers and counters 0
- Reset mid-operation overrides everything, including an in-flight `loader_start`, and returns all of the above values on the next edge.
- Power-up latency:
  - `power_good` set high before edge 0 reaches `pg_s` at edge 2.
  - LATCH is entered at edge 2+PG_FILTER.
  - LOAD is entered one edge later, and `loader_start` is high in that cycle.
- A `loader_done` sampled at edge N in LOAD gives WARMUP from edge N.
- RUN outputs appear WARMUP edges after WARMUP is entered.
- Power-loss latency: `power_good` falling before edge 0 drops `bubble_interface_enable` and raises `temperature_low` at edge 3 (2 sync + 1 register).
- A power_good glitch shorter than PG_FILTER samples in WAIT_PG restarts the filter and never reaches LATCH.

## Test plan
- PG_FILTER=4, WARMUP=8, `image_dip_switch=3'b010`, `function_dip_switch=4'b1110`:
  - `power_good` rises → LATCH after 6 edges.
  - `image_number=5`, `function_mode=1`.
  - One `loader_start` pulse.
  - `loader_done` 3 cycles later → RUN 8 edges after WARMUP entry, with enable=1 and `temperature_low=0`.
- `power_good` high for 3 edges then low, repeated → state stays 0 and `loader_start` is never asserted.
- In LOAD, assert `flash_error` and `loader_done` together → FAULT, `boot_error=1`, enable 0. Then drop `power_good` → `boot_error=0` 3 edges later.
- LOAD_TIMEOUT=10 with no `loader_done` → FAULT exactly 10 cycles after LOAD entry.
- In RUN, change the DIP switches → `image_number` and `function_mode` unchanged. Power-cycle → new values latched.
- Assert `reset` in WARMUP and in RUN → all outputs at reset values on the next edge. Deassert → a normal boot follows.
